muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_if.sv | 34 +++
 rtl/muldiv_div_step.sv | 20 ++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MADD  = 3'd4,
    MADDU = 3'd5,
    MSUB  = 3'd6,
    MSUBU = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Even opcodes are the signed variants.
  function automatic logic is_signed(muldiv_op_t op);
    return !op[0];
  endfunction

  function automatic logic is_div(muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Accumulating ops start from the current HI/LO pair instead of zero.
  function automatic logic is_acc(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_sub(muldiv_op_t op);
    return (op == MSUB) || (op == MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request, status, result and direct-write signals of the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hold;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             hi_we;
  logic [WIDTH-1:0] hi_wdata;
  logic             lo_we;
  logic [WIDTH-1:0] lo_wdata;

  modport master (
    output start, op, src_a, src_b, hold, cancel,
    output hi_we, hi_wdata, lo_we, lo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hold, cancel,
    input  hi_we, hi_wdata, lo_we, lo_wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_out
);

  logic [WIDTH:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_out   = (shifted >= {1'b0, divisor});
  // While rem_in < divisor the difference always fits back into WIDTH bits.
  assign rem_out = q_out ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: radix-2
// shift-add multiply and restoring divide, one step per clock.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b0
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  muldiv_state_t      state;
  muldiv_op_t         op_r;
  logic [CW-1:0]      count;
  // For divides, acc[WIDTH-1:0] keeps the raw dividend (for divide-by-zero)
  // and mcand[WIDTH-1:0] holds the divisor magnitude; mplier is the dividend
  // magnitude shifting out while quotient bits shift in.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               a_neg;
  logic               b_neg;
  logic               div_zero;
  logic               busy_r;
  logic               done_r;

  logic               a_sgn;
  logic               b_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic               pp_neg;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  logic               mul_early;

  assign a_sgn = is_signed(bus.op) & bus.src_a[WIDTH-1];
  assign b_sgn = is_signed(bus.op) & bus.src_b[WIDTH-1];
  assign a_mag = a_sgn ? -bus.src_a : bus.src_a;
  assign b_mag = b_sgn ? -bus.src_b : bus.src_b;

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .bit_in  (mplier[WIDTH-1]),
    .divisor (mcand[WIDTH-1:0]),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // A signed multiplier's top bit weighs -2^(WIDTH-1), so the last step
  // subtracts; MSUB flips every partial product to a subtraction.
  assign pp_neg = is_sub(op_r) ^ (is_signed(op_r) && (count == CW'(1)));
  assign pp     = pp_neg ? -mcand : mcand;

  assign quo_res   = div_zero ? '1 : ((a_neg ^ b_neg) ? -mplier : mplier);
  assign rem_res   = div_zero ? acc[WIDTH-1:0] : (a_neg ? -rem : rem);
  assign mul_early = EARLY_TERM && !is_div(op_r) && (mplier == '0);

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // Control FSM with the datapath iterations and HI/LO commit/write logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_r     <= MULT;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            op_r     <= bus.op;
            a_neg    <= a_sgn;
            b_neg    <= b_sgn;
            div_zero <= (bus.src_b == '0);
            rem      <= '0;
            count    <= STEPS;
            if (is_div(bus.op)) begin
              acc    <= {{WIDTH{1'b0}}, bus.src_a};
              mcand  <= {{WIDTH{1'b0}}, b_mag};
              mplier <= a_mag;
            end else begin
              acc    <= is_acc(bus.op) ? {hi_r, lo_r} : '0;
              mcand  <= {{WIDTH{a_sgn}}, bus.src_a};
              mplier <= bus.src_b;
            end
            state  <= BUSY;
            busy_r <= 1'b1;
          end else begin
            if (bus.hi_we) hi_r <= bus.hi_wdata;
            if (bus.lo_we) lo_r <= bus.lo_wdata;
          end
        end
        BUSY: begin
          if (bus.cancel) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            count  <= '0;
          end else if ((count == '0) || mul_early) begin
            if (is_div(op_r)) begin
              hi_r <= rem_res;
              lo_r <= quo_res;
            end else begin
              hi_r <= acc[2*WIDTH-1:WIDTH];
              lo_r <= acc[WIDTH-1:0];
            end
            count  <= '0;
            state  <= DONE;
            done_r <= 1'b1;
          end else if (is_div(op_r)) begin
            rem    <= step_rem;
            mplier <= {mplier[WIDTH-2:0], step_q};
            count  <= count - CW'(1);
          end else begin
            if (mplier[0]) acc <= acc + pp;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
          end
        end
        DONE: begin
          if (bus.hi_we) hi_r <= bus.hi_wdata;
          if (bus.lo_we) lo_r <= bus.lo_wdata;
          if (bus.cancel || !bus.hold) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, EARLY_TERM=0): vector table,
// random ops against a reference model, and hand-written control sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .EARLY_TERM(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    string      name;
    muldiv_op_t op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[17];

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(muldiv_op_t op, logic [31:0] a, logic [31:0] b, logic [63:0] pre);
    longint      sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MULT:    return 64'(sa * sb);
      MULTU:   return ua * ub;
      MADD:    return pre + 64'(sa * sb);
      MADDU:   return pre + ua * ub;
      MSUB:    return pre - 64'(sa * sb);
      MSUBU:   return pre - ua * ub;
      DIV:     return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      DIVU:    return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
      default: return 64'h0;
    endcase
  endfunction

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    bus.hi_we = 1'b1; bus.hi_wdata = h;
    bus.lo_we = 1'b1; bus.lo_wdata = l;
    @(posedge clk);
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // Drives one start pulse; returns at the falling edge after the accept edge.
  task automatic apply_stimulus(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                input bit push, input logic [63:0] expv, input bit with_write);
    @(negedge clk);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    if (with_write) begin
      bus.hi_we = 1'b1; bus.hi_wdata = 32'h99;
      bus.lo_we = 1'b1; bus.lo_wdata = 32'h88;
    end
    if (push) sb_q.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.busy) busy_ok = 1'b0;
  endtask

  task automatic pop_expected(output logic [63:0] expv);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
      expv = 64'h0;
    end else begin
      expv = sb_q.pop_front();
    end
  endtask

  task automatic finish_op(input string name);
    int          lat;
    bit          busy_ok;
    logic [63:0] expv;
    wait_done(lat, busy_ok);
    check_output({name, "_latency"}, 64'(lat), 64'd33);
    check_output({name, "_busy"}, {63'b0, busy_ok}, 64'd1);
    pop_expected(expv);
    check_output({name, "_result"}, {bus.hi, bus.lo}, expv);
    @(posedge clk);
    @(negedge clk);
    check_output({name, "_release"}, {62'b0, bus.busy, bus.done}, 64'd0);
  endtask

  initial begin
    int          lat;
    int          cnt;
    bit          busy_ok;
    bit          bad;
    logic [63:0] expv;
    logic [31:0] ra, rb, rh, rl;
    muldiv_op_t  rop;

    vecs[0]  = '{"mult_neg2x3",  MULT,  32'hFFFFFFFE, 32'h3,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_max",    MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,        32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"mult_m1xm1",   MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h0,        32'h1};
    vecs[3]  = '{"mult_minxmin", MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0,        32'h40000000, 32'h0};
    vecs[4]  = '{"multu_zero",   MULTU, 32'h12345678, 32'h0,        32'h9, 32'h9,        32'h0,        32'h0};
    vecs[5]  = '{"mult_7xm3",    MULT,  32'h7,        32'hFFFFFFFD, 32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6]  = '{"div_m7_2",     DIV,   32'hFFFFFFF9, 32'h2,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{"divu_by0",     DIVU,  32'h7,        32'h0,        32'h0, 32'h0,        32'h7,        32'hFFFFFFFF};
    vecs[8]  = '{"div_ovf",      DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h0,        32'h80000000};
    vecs[9]  = '{"divu_100_7",   DIVU,  32'h64,       32'h7,        32'h0, 32'h0,        32'h2,        32'hE};
    vecs[10] = '{"div_7_m2",     DIV,   32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,        32'h1,        32'hFFFFFFFD};
    vecs[11] = '{"div_by0",      DIV,   32'hFFFFFFF9, 32'h0,        32'h0, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[12] = '{"maddu_wrap",   MADDU, 32'h1,        32'h1,        32'h0, 32'hFFFFFFFF, 32'h1,        32'h0};
    vecs[13] = '{"msub_back",    MSUB,  32'h1,        32'h1,        32'h1, 32'h0,        32'h0,        32'hFFFFFFFF};
    vecs[14] = '{"madd_neg",     MADD,  32'hFFFFFFFF, 32'h3,        32'h0, 32'h5,        32'h0,        32'h2};
    vecs[15] = '{"msubu_under",  MSUBU, 32'h1,        32'h1,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[16] = '{"divu_big",     DIVU,  32'hFFFFFFFF, 32'h10,       32'h0, 32'h0,        32'hF,        32'h0FFFFFFF};

    bus.start = 1'b0; bus.op = MULT; bus.src_a = '0; bus.src_b = '0;
    bus.hold = 1'b0; bus.cancel = 1'b0;
    bus.hi_we = 1'b0; bus.hi_wdata = '0; bus.lo_we = 1'b0; bus.lo_wdata = '0;
    rst = 1'b0;

    // Reset state, observed before any clock edge.
    #2 rst = 1'b1;
    #2;
    check_output("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    check_output("reset_status", {62'b0, bus.busy, bus.done}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, {vecs[i].exp_hi, vecs[i].exp_lo}, 1'b0);
      finish_op(vecs[i].name);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = muldiv_op_t'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      preload(rh, rl);
      apply_stimulus(rop, ra, rb, 1'b1, model(rop, ra, rb, {rh, rl}), 1'b0);
      finish_op($sformatf("rand%0d_%s", i, rop.name()));
    end

    // start wins over a same-cycle direct write.
    preload(32'h11, 32'h22);
    apply_stimulus(MULTU, 32'h2, 32'h3, 1'b1, 64'h6, 1'b1);
    check_output("start_wins_write_dropped", {bus.hi, bus.lo}, {32'h11, 32'h22});
    finish_op("start_wins");

    // Cancel in BUSY; a direct write during BUSY is ignored.
    preload(32'hAAAA5555, 32'h12345678);
    check_output("cancel_preload", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h12345678});
    apply_stimulus(DIV, 32'h64, 32'h7, 1'b0, 64'h0, 1'b0);
    bad = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) bad = 1'b1;
      bus.hi_we = (k == 5); bus.hi_wdata = 32'hDEADBEEF;
      bus.cancel = (k == 10);
    end
    check_output("cancel_status", {62'b0, bus.busy, bus.done}, 64'h0);
    check_output("cancel_hilo", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h12345678});
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy || {bus.hi, bus.lo} !== {32'hAAAA5555, 32'h12345678}) bad = 1'b1;
    end
    check_output("cancel_no_done", {63'b0, bad}, 64'h0);

    // hold keeps DONE; start in DONE is ignored; next start in IDLE accepted.
    bus.hold = 1'b1;
    apply_stimulus(MULTU, 32'h3, 32'h5, 1'b1, 64'd15, 1'b0);
    wait_done(lat, busy_ok);
    check_output("hold_latency", 64'(lat), 64'd33);
    cnt = 0;
    while (bus.done && cnt < 10) begin
      cnt++;
      bus.start = (cnt == 1); bus.op = MULTU; bus.src_a = 32'h2; bus.src_b = 32'h2;
      if (cnt == 4) bus.hold = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.hold = 1'b0;
    check_output("hold_done_cycles", 64'(cnt), 64'd4);
    check_output("hold_start_ignored", {62'b0, bus.busy, bus.done}, 64'h0);
    pop_expected(expv);
    check_output("hold_result", {bus.hi, bus.lo}, expv);
    apply_stimulus(MULTU, 32'h2, 32'h2, 1'b1, 64'd4, 1'b0);
    finish_op("after_hold");

    // Asynchronous reset in the middle of a multiply.
    preload(32'h55, 32'h66);
    apply_stimulus(MULT, 32'hFFFFFFFE, 32'h3, 1'b0, 64'h0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_hilo", {bus.hi, bus.lo}, 64'h0);
    check_output("async_reset_status", {62'b0, bus.busy, bus.done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy || {bus.hi, bus.lo} !== 64'h0) bad = 1'b1;
    end
    check_output("async_reset_no_commit", {63'b0, bad}, 64'h0);

    check_output("scoreboard_drained", 64'(sb_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
